bcd_pulse_generator: RTL
========================

// Module: bcd_pulse_generator
// PURPOSE
//   Stimulus-side counterpart of the pulse counter: takes a two-digit BCD count (Tens, Units),
//   emits exactly that many clean pulses on Pulse, each HIGH_CYCLES clocks high and separated
//   by LOW_CYCLES clocks low, so the 4-cycle-high pulse detector counts each one exactly once.
//   Drives the counter's Pulse input in loopback/self-test; Done/Busy let a sequencer chain runs.
// PARAMETERS
//   HIGH_CYCLES  4   clocks Pulse is held high per pulse (>=1; >=4 for the detector to register it)
//   LOW_CYCLES   4   clocks Pulse is held low after each pulse (>=1)
//   MAX_COUNT    31  largest accepted request (5-bit counter capacity); larger -> Error
// PORTS
//   CLK     in   1  system clock, all logic on rising edge
//   Reset   in   1  asynchronous, active-low reset (0 = reset)
//   Start   in   1  request strobe; sampled only in IDLE
//   Tens    in   4  BCD tens digit of the requested pulse count
//   Units   in   4  BCD units digit of the requested pulse count
//   Pulse   out  1  generated pulse train (registered)
//   Busy    out  1  high from the cycle after an accepted Start through the DONE cycle
//   Done    out  1  one-cycle strobe: train finished (also for zero-count requests)
//   Error   out  1  one-cycle strobe: request rejected, no pulses emitted
// BEHAVIOUR
//   Reset (async, Reset=0): state IDLE; Pulse=0, Busy=0, Done=0, Error=0; counters cleared.
//   All outputs registered; no combinational input->output paths.
//   States: IDLE -> LOAD -> {HIGH <-> LOW} -> DONE -> IDLE; IDLE -> ERR -> IDLE.
//   IDLE: Start=1 at edge k latches Tens/Units. Invalid if Tens>9, Units>9, or
//     N = Tens*10+Units > MAX_COUNT -> ERR at k+1 (Error=1 one cycle, Busy stays 0), then IDLE.
//     Valid -> LOAD at k+1, Busy=1.
//   LOAD: N computed as Tens*8+Tens*2+Units (6-bit intermediate, stored in 5-bit remaining count).
//     N=0 -> DONE at k+2. Else -> HIGH at k+2: Pulse=1 from cycle k+2.
//   HIGH: Pulse=1 for exactly HIGH_CYCLES cycles, then LOW.
//   LOW: Pulse=0 for exactly LOW_CYCLES cycles; remaining decremented on entry to LOW;
//     at end of LOW: remaining!=0 -> HIGH, remaining==0 -> DONE.
//   DONE: Done=1 and Busy=1 for one cycle, then IDLE (Busy=0). Start in DONE cycle ignored;
//     next request accepted from the first IDLE cycle.
//   Total Start-to-Done latency, N>0: 2 + N*(HIGH_CYCLES+LOW_CYCLES) cycles; N=0: 2 cycles.
//   Start while Busy or in ERR: ignored, no queuing; latched digits unaffected by input changes.
//   Start held high continuously: one request per IDLE visit (level-sampled, not edge).
//   Reset asserted mid-train: Pulse drops to 0 immediately (async), train aborted, no Done.
//   Done and Error never asserted in the same cycle; Pulse is always 0 in IDLE/LOAD/DONE/ERR.
// TESTING
//   Reset, then Tens=0 Units=3 Start one cycle -> Pulse high k+2..k+5, 3 pulses total,
//     Done at k+26, Busy high k+1..k+26; loopback into counter -> Tens=0 Units=3.
//   Tens=3 Units=1 (31) -> 31 pulses, each exactly 4 high / 4 low, Done at k+250; no Error.
//   Tens=0 Units=0 -> no Pulse, Done at k+2, Busy high k+1..k+2.
//   Tens=3 Units=2 (32) and Tens=1 Units=10 -> Error one cycle at k+1, Busy/Pulse stay 0.
//   Start re-pulsed mid-train with new digits -> ignored; pulse count matches first request.
//   Reset low during 2nd pulse high phase -> Pulse=0 same cycle, Busy=0, no Done;
//     after release, new Start Units=2 -> exactly 2 pulses.

Source files
------------

// File: rtl/bcd_pulse_generator.sv
// bcd_pulse_generator
// Turns a two-digit BCD request (Tens, Units) into that many clean pulses on
// Pulse. Each pulse is HIGH_CYCLES clocks high, followed by LOW_CYCLES clocks
// low, so a 4-cycle-high pulse detector counts every pulse exactly once.
// Busy covers the whole accepted run. Done marks the end of a run. Error
// marks a rejected request. All outputs are registered.

module bcd_pulse_generator #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int MAX_COUNT   = 31
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] Tens,
    input  logic [3:0] Units,
    output logic       Pulse,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    // The phase counter must be wide enough for the longer of the two phases.
    localparam int PHASE_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CNT_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [7:0]       MAX_REQ   = 8'(MAX_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [3:0]       r_tens;
    logic [3:0]       r_units;
    logic [4:0]       r_remaining;
    logic [CNT_W-1:0] r_phaseCnt;

    logic             r_pulse;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic [7:0]       w_reqCount;
    logic             w_digitsOk;
    logic             w_requestValid;
    logic [5:0]       w_loadCount;
    logic             w_highLast;
    logic             w_lowLast;

    // Validate the live request digits so IDLE can choose between LOAD and ERR.
    always_comb begin
        w_reqCount     = ({4'b0000, Tens} * 8'd10) + {4'b0000, Units};
        w_digitsOk     = (Tens <= 4'd9) && (Units <= 4'd9);
        w_requestValid = w_digitsOk && (w_reqCount <= MAX_REQ);
    end

    // Convert the latched digits to binary with shifts and adds: Tens*8 + Tens*2 + Units.
    always_comb begin
        w_loadCount = {r_tens[2:0], 3'b000} + {1'b0, r_tens, 1'b0} + {2'b00, r_units};
        w_highLast  = (r_phaseCnt == HIGH_LAST);
        w_lowLast   = (r_phaseCnt == LOW_LAST);
    end

    // Hold the current state. Reset aborts any train in progress.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Choose the next state. Start only has an effect in IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_nextState = w_requestValid ? S_LOAD : S_ERR;
                end
            end
            S_LOAD: begin
                w_nextState = (w_loadCount == 6'd0) ? S_DONE : S_HIGH;
            end
            S_HIGH: begin
                if (w_highLast) begin
                    w_nextState = S_LOW;
                end
            end
            S_LOW: begin
                if (w_lowLast) begin
                    w_nextState = (r_remaining == 5'd0) ? S_DONE : S_HIGH;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            S_ERR: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Capture the digits only when a valid request is accepted.
    // Later input changes cannot disturb the run in progress.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else if ((r_state == S_IDLE) && Start && w_requestValid) begin
            r_tens  <= Tens;
            r_units <= Units;
        end
    end

    // Track the pulses still to send and the cycles spent in the current phase.
    // A pulse is consumed as the train enters its low phase.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_remaining <= 5'd0;
            r_phaseCnt  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_remaining <= w_loadCount[4:0];
                    r_phaseCnt  <= '0;
                end
                S_HIGH: begin
                    if (w_highLast) begin
                        r_phaseCnt  <= '0;
                        r_remaining <= r_remaining - 5'd1;
                    end else begin
                        r_phaseCnt <= r_phaseCnt + 1'b1;
                    end
                end
                S_LOW: begin
                    if (w_lowLast) begin
                        r_phaseCnt <= '0;
                    end else begin
                        r_phaseCnt <= r_phaseCnt + 1'b1;
                    end
                end
                default: begin
                    r_phaseCnt <= '0;
                end
            endcase
        end
    end

    // Register the outputs from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_pulse <= (w_nextState == S_HIGH);
            r_busy  <= (w_nextState == S_LOAD) || (w_nextState == S_HIGH) ||
                       (w_nextState == S_LOW)  || (w_nextState == S_DONE);
            r_done  <= (w_nextState == S_DONE);
            r_error <= (w_nextState == S_ERR);
        end
    end

    assign Pulse = r_pulse;
    assign Busy  = r_busy;
    assign Done  = r_done;
    assign Error = r_error;

endmodule
